// File: rtl/oram_arbiter_pkg.sv
// oram_arbiter_pkg: arbiter state encoding and starve-counter width shared by the oram arbiter files
package oram_arbiter_pkg;
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_CLEAR = 2'd2
  } arb_state_t;
  localparam int ARB_SNL = 2;
endpackage

// File: rtl/oram_grant.sv
// oram_grant: combinational emit/patch select; ports: idle/clear gate, valids, full, starve_cnt in; one-hot grants out
module oram_grant
  import oram_arbiter_pkg::*;
#(
  parameter int STARVE_LIM = 3
) (
  input  logic               idle,
  input  logic               clear,
  input  logic               emit_valid,
  input  logic               patch_valid,
  input  logic               full,
  input  logic [ARB_SNL-1:0] starve_cnt,
  output logic               emit_grant,
  output logic               patch_grant
);
  logic open, emit_ok, patch_win;
  always_comb begin
    open        = idle && !clear;
    emit_ok     = emit_valid && !full;
    // patch takes the slot when emit cannot use it or emit has starved it long enough
    patch_win   = patch_valid && (!emit_ok || starve_cnt == ARB_SNL'(STARVE_LIM));
    emit_grant  = open && emit_ok && !patch_win;
    patch_grant = open && patch_win;
  end
endmodule

// File: rtl/oram_arbiter.sv
// oram_arbiter: sequences oram writes from emit stream and patch unit; ports: clk/reset/clear, emit and patch handshakes, held mem write port, wr_ptr/full status
module oram_arbiter
  import oram_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              emit_valid,
  input  logic [DATA_W-1:0] emit_data,
  output logic              emit_ready,
  input  logic              patch_valid,
  input  logic [ADDR_W-1:0] patch_addr,
  input  logic [DATA_W-1:0] patch_data,
  output logic              patch_ready,
  output logic              patch_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              full
);
  arb_state_t         state;
  logic               clear_pend, emit_grant, patch_grant, patch_bad;
  logic [ARB_SNL-1:0] starve_cnt;
  assign full       = &wr_ptr;
  assign patch_bad  = patch_addr >= wr_ptr;
  assign emit_ready  = emit_grant;
  assign patch_ready = patch_grant;
  oram_grant #(.STARVE_LIM(STARVE_LIM)) u_grant (
    .idle        (state == ARB_IDLE),
    .clear       (clear),
    .emit_valid  (emit_valid),
    .patch_valid (patch_valid),
    .full        (full),
    .starve_cnt  (starve_cnt),
    .emit_grant  (emit_grant),
    .patch_grant (patch_grant)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      wr_ptr     <= '0;
      starve_cnt <= '0;
      patch_err  <= 1'b0;
      clear_pend <= 1'b0;
    end else begin
      patch_err <= patch_grant && patch_bad;
      if (!patch_valid || patch_grant)
        starve_cnt <= '0;
      else if (emit_grant && starve_cnt != ARB_SNL'(STARVE_LIM))
        starve_cnt <= starve_cnt + 1'b1;
      case (state)
        ARB_IDLE:
          if (clear) begin
            wr_ptr     <= '0;
            starve_cnt <= '0;
          end else if (emit_grant) begin
            mem_addr  <= wr_ptr;
            mem_wdata <= emit_data;
            mem_req   <= 1'b1;
            wr_ptr    <= wr_ptr + 1'b1;
            state     <= ARB_BUSY;
          end else if (patch_grant && !patch_bad) begin
            mem_addr  <= patch_addr;
            mem_wdata <= patch_data;
            mem_req   <= 1'b1;
            state     <= ARB_BUSY;
          end
        ARB_BUSY: begin
          if (clear) clear_pend <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= (clear || clear_pend) ? ARB_CLEAR : ARB_IDLE;
          end
        end
        ARB_CLEAR: begin
          wr_ptr     <= '0;
          starve_cnt <= '0;
          clear_pend <= 1'b0;
          state      <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end
endmodule
